// File: rtl/bin_to_bcd_mux.sv
// bin_to_bcd_mux: converts a signed 10-bit value to sign + three BCD digits
// with a shift-and-add-3 engine, then time-multiplexes the digits for a
// display through a free-running slot counter.
//
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   start       - conversion request, accepted only when idle and not busy
//   value       - signed two's-complement input (-512..511)
//   busy        - conversion in progress (includes the done cycle)
//   done        - one-cycle pulse when a result is committed
//   num         - BCD digit for the current slot (0 for the sign slot)
//   sign        - committed result is negative
//   count       - slot select: 0 ones, 1 tens, 2 hundreds, 3 sign
//   en          - display enable, set by the first commit
module bin_to_bcd_mux #(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned WIDTH       = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] value,
  output logic             busy,
  output logic             done,
  output logic [3:0]       num,
  output logic             sign,
  output logic [1:0]       count,
  output logic             en
);

  localparam int unsigned BCD_W = 12;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned RW    = $clog2(REFRESH_DIV);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    SHIFT  = 2'd2,
    COMMIT = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   val_q, val_d;
  logic [WIDTH-1:0]   mag_q, mag_d;
  logic               psign_q, psign_d;
  logic [BCD_W-1:0]   scratch_q, scratch_d;
  logic [CNT_W-1:0]   shcnt_q, shcnt_d;
  logic [3:0]         ones_q, ones_d;
  logic [3:0]         tens_q, tens_d;
  logic [3:0]         hund_q, hund_d;
  logic               valid_q, valid_d;
  logic [RW-1:0]      refresh_q, refresh_d;

  logic               busy_d, done_d, sign_d, en_d;
  logic [3:0]         num_d;
  logic [1:0]         count_d;

  logic [3:0]         adj0, adj1;
  logic [2:0]         adj2;
  logic [BCD_W-1:0]   shifted;
  logic               wrap;

  // Add-3 correction ahead of each shift. The magnitude never exceeds 512,
  // so the hundreds nibble cannot carry out of its low three bits.
  always_comb begin
    adj0    = (scratch_q[3:0] >= 4'd5) ? scratch_q[3:0] + 4'd3 : scratch_q[3:0];
    adj1    = (scratch_q[7:4] >= 4'd5) ? scratch_q[7:4] + 4'd3 : scratch_q[7:4];
    adj2    = (scratch_q[11:8] >= 4'd5) ? 3'(scratch_q[10:8] + 3'd3) : scratch_q[10:8];
    shifted = {adj2, adj1, adj0, mag_q[WIDTH-1]};
  end

  // Next-state, datapath and registered-output logic.
  always_comb begin
    state_d   = state_q;
    val_d     = val_q;
    mag_d     = mag_q;
    psign_d   = psign_q;
    scratch_d = scratch_q;
    shcnt_d   = shcnt_q;
    ones_d    = ones_q;
    tens_d    = tens_q;
    hund_d    = hund_q;
    valid_d   = valid_q;
    sign_d    = sign;
    done_d    = 1'b0;
    busy_d    = (state_q != IDLE);

    case (state_q)
      IDLE: begin
        if (start && !busy) begin
          val_d   = value;
          state_d = LOAD;
        end
      end
      LOAD: begin
        // |value| fits in WIDTH unsigned bits (512 included), so the extra
        // magnitude bit is always zero and is not stored.
        psign_d   = val_q[WIDTH-1];
        mag_d     = val_q[WIDTH-1] ? WIDTH'(~val_q + WIDTH'(1)) : val_q;
        scratch_d = '0;
        shcnt_d   = CNT_W'(WIDTH);
        state_d   = SHIFT;
      end
      SHIFT: begin
        scratch_d = shifted;
        mag_d     = {mag_q[WIDTH-2:0], 1'b0};
        shcnt_d   = shcnt_q - CNT_W'(1);
        if (shcnt_q == CNT_W'(1)) begin
          state_d = COMMIT;
        end
      end
      COMMIT: begin
        ones_d  = scratch_q[3:0];
        tens_d  = scratch_q[7:4];
        hund_d  = scratch_q[11:8];
        sign_d  = psign_q;
        valid_d = 1'b1;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Free-running slot refresh, independent of the converter.
    wrap      = (refresh_q == RW'(REFRESH_DIV - 1));
    refresh_d = wrap ? '0 : refresh_q + RW'(1);
    count_d   = wrap ? count + 2'd1 : count;

    // Digit mux driven from next-cycle values so num always matches count.
    case (count_d)
      2'd0:    num_d = ones_d;
      2'd1:    num_d = tens_d;
      2'd2:    num_d = hund_d;
      default: num_d = 4'd0;
    endcase

    en_d = valid_d;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      val_q     <= '0;
      mag_q     <= '0;
      psign_q   <= 1'b0;
      scratch_q <= '0;
      shcnt_q   <= '0;
      ones_q    <= '0;
      tens_q    <= '0;
      hund_q    <= '0;
      valid_q   <= 1'b0;
      refresh_q <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      num       <= '0;
      sign      <= 1'b0;
      count     <= '0;
      en        <= 1'b0;
    end else begin
      state_q   <= state_d;
      val_q     <= val_d;
      mag_q     <= mag_d;
      psign_q   <= psign_d;
      scratch_q <= scratch_d;
      shcnt_q   <= shcnt_d;
      ones_q    <= ones_d;
      tens_q    <= tens_d;
      hund_q    <= hund_d;
      valid_q   <= valid_d;
      refresh_q <= refresh_d;
      busy      <= busy_d;
      done      <= done_d;
      num       <= num_d;
      sign      <= sign_d;
      count     <= count_d;
      en        <= en_d;
    end
  end

endmodule

// File: doc/bin_to_bcd_mux.md
BIN_TO_BCD_MUX -- requirements
Module: bin_to_bcd_mux

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 100000: clk cycles per display digit slot (legal range >= 2).
REQ-002 SHALL have parameter WIDTH, default 10: width of the signed input value; fixed at 10 for this revision.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  request conversion of value; sampled only in IDLE.
REQ-006 value  input  10  signed two's-complement result to display, range -512..511.
REQ-007 busy  output  1  high while a conversion is in progress.
REQ-008 done  output  1  one-cycle pulse when a new result is committed to the display registers.
REQ-009 num  output  4  BCD digit for the currently selected slot.
REQ-010 sign  output  1  committed result is negative (1) or non-negative (0).
REQ-011 count  output  2  digit slot select: 0 ones, 1 tens, 2 hundreds, 3 sign.
REQ-012 en  output  1  display enable; high once a valid result has been committed.

Function
REQ-013 SHALL implement FSM states IDLE, LOAD, SHIFT, COMMIT.
REQ-014 IDLE: if start=1, SHALL latch value and go to LOAD; otherwise stay in IDLE.
REQ-015 LOAD: SHALL form an 11-bit magnitude (-512 -> 512) and a pending sign (value[9]), clear a 12-bit BCD scratch register, load shift count 10, and go to SHIFT.
REQ-016 SHIFT: each cycle SHALL add 3 to every scratch nibble >= 5, then shift {scratch, magnitude} left by 1; after the 10th shift, go to COMMIT.
REQ-017 COMMIT: SHALL copy scratch into the ones, tens and hundreds display registers, copy the pending sign into sign, pulse done=1 for this cycle only, set the valid flag, and return to IDLE.
REQ-018 Latency: start sampled high at edge N SHALL give done=1 in the cycle after edge N+12; busy SHALL be 1 from edge N+1 through the cycle in which done is high.
REQ-019 start while busy=1 SHALL be ignored; no queuing.
REQ-020 Display registers SHALL hold the previous result unchanged until COMMIT, so no partial digits are ever shown.
REQ-021 Zero SHALL display as sign=0; the value -0 cannot occur. -512 SHALL display as hundreds=5, tens=1, ones=2, sign=1.
REQ-022 A refresh counter SHALL count 0..REFRESH_DIV-1 continuously, independent of the FSM; on wrap, count SHALL increment modulo 4 (3 -> 0).
REQ-023 num SHALL be registered ones, tens or hundreds for count 0, 1 or 2, and 4'd0 for count 3.
REQ-024 en SHALL equal the valid flag; the valid flag is cleared only by reset.
REQ-025 SHALL keep count, num, sign and en free of combinational paths from start or value.

Reset
REQ-026 rst_n=0 SHALL immediately force the following, regardless of clk: FSM to IDLE, busy=0, done=0, sign=0, en=0, count=0, num=0, refresh counter=0, and all display, scratch and valid registers to 0.
REQ-027 A reset during LOAD or SHIFT SHALL abort the conversion with no done pulse; the first rising clk edge after rst_n rises SHALL see IDLE.

Verification
REQ-028 Apply reset, then run 50 cycles with start=0 -> busy=0, done=0, en=0, num=0, sign=0, count advances 0,1,2,3,0 every REFRESH_DIV cycles.
REQ-029 start pulse with value=10'd123 -> done exactly 12 cycles later; ones=3, tens=2, hundreds=1, sign=0, en=1; num reads 3, 2, 1, 0 across count 0..3.
REQ-030 value=-10'd512 (10'h200), then value=-10'd7 -> 5/1/2 with sign=1, then 0/0/7 with sign=1; value=0 -> 0/0/0 with sign=0.
REQ-031 start with 45, then start held high with 99 for the next 5 cycles -> one done only, displaying 045; display holds 045 during the second conversion (99 issued after done) until its commit.
REQ-032 Assert rst_n=0 at SHIFT iteration 4 with 300 after a prior commit of 111 -> outputs zero immediately, en=0, no done pulse; a following start with 300 commits 3/0/0.
REQ-033 Sweep all 1024 input values against a reference model -> digits and sign match for every value, with done latency always 12 cycles.
